// File: rtl/fp8_pkg.sv
// fp8_pkg: E4M3 FP8 and float32 field constants shared by the FP8 packer and unpacker.
package fp8_pkg;
    localparam int E4M3_BIAS = 7;
    localparam int E4M3_EW = 4;
    localparam int E4M3_MW = 3;
    localparam logic [3:0] E4M3_EXP_SPC = 4'hF;
    localparam logic [22:0] F32_QNAN_FRAC = 23'h400000;
    localparam int F32_EXP_BIAS = 127;
    typedef struct packed {
        logic s;
        logic [E4M3_EW-1:0] e;
        logic [E4M3_MW-1:0] m;
    } e4m3_t;
endpackage

// File: rtl/fp8e4_to_f32.sv
// fp8e4_to_f32: exact combinational widening of one E4M3 byte to float32 bits.
module fp8e4_to_f32
    import fp8_pkg::*;
(
    input  logic [7:0]  code,
    output logic [31:0] f32,
    output logic        spc
);
    e4m3_t x;
    logic [7:0] exp;
    logic [22:0] frac;
    assign x = code;
    always_comb begin
        // subnormals renormalise on the leading one of m
        exp = x.e == '0 ? (x.m[2] ? 8'd120 : x.m[1] ? 8'd119 : 8'd118)
                        : {4'b0, x.e} + 8'(F32_EXP_BIAS - E4M3_BIAS);
        frac = x.e == '0 ? (x.m[2] ? {x.m[1:0], 21'b0} : x.m[1] ? {x.m[0], 22'b0} : 23'b0)
                         : {x.m, 20'b0};
        spc = x.e == E4M3_EXP_SPC;
        f32 = spc ? {x.s, 8'hFF, x.m != '0 ? F32_QNAN_FRAC : 23'b0}
            : (x.e == '0 && x.m == '0) ? {x.s, 31'b0}
            : {x.s, exp, frac};
    end
endmodule

// File: rtl/fp8e4_unpack_stream.sv
// fp8e4_unpack_stream: unpacks LANES-byte E4M3 words into one float32 per cycle over valid/ready.
module fp8e4_unpack_stream
    import fp8_pkg::*;
#(
    parameter int LANES = 4,
    parameter int LW = $clog2(LANES)
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [8*LANES-1:0] in_data_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [31:0]        out_f32_o,
    output logic [LW-1:0]      out_lane_o,
    output logic               out_last_o,
    output logic               out_spc_o
);
    logic [8*LANES-1:0] hold_q;
    logic hold_v;
    logic [LW-1:0] idx_q;
    logic [7:0] lane;
    logic [31:0] f32;
    logic spc, last, adv, acc;
    assign lane = hold_q[{idx_q, 3'b000} +: 8];
    assign last = idx_q == LW'(LANES - 1);
    assign adv = hold_v && (!out_valid_o || out_ready_i);
    // a new word may land in the same cycle the last lane leaves, so words stream without a bubble
    assign in_ready_o = !rst_i && (!hold_v || (adv && last));
    assign acc = in_valid_i && in_ready_o;
    fp8e4_to_f32 dec (
        .code(lane),
        .f32(f32),
        .spc(spc)
    );
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hold_v <= 1'b0;
            idx_q <= '0;
            out_valid_o <= 1'b0;
            out_f32_o <= '0;
            out_lane_o <= '0;
            out_last_o <= 1'b0;
            out_spc_o <= 1'b0;
        end else begin
            if (adv) begin
                idx_q <= last ? '0 : idx_q + 1'b1;
                if (last) hold_v <= 1'b0;
            end
            if (acc) begin
                hold_q <= in_data_i;
                hold_v <= 1'b1;
                idx_q <= '0;
            end
            if (adv) begin
                out_valid_o <= 1'b1;
                out_f32_o <= f32;
                out_lane_o <= idx_q;
                out_last_o <= last;
                out_spc_o <= spc;
            end else if (out_ready_i) begin
                out_valid_o <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fp8e4_unpack_stream.sv
// tb_fp8e4_unpack_stream: directed and randomized checks of the E4M3 stream unpacker against a value-level model.
module tb_fp8e4_unpack_stream;
    localparam int LANES = 4;
    logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
    logic in_ready, out_valid, out_last, out_spc;
    logic [31:0] in_data = 0, out_f32;
    logic [1:0] out_lane;
    int checks = 0, errors = 0;
    typedef struct {
        logic [7:0] b;
        int lane;
    } exp_t;
    exp_t q[$];
    exp_t e_sb;

    always #5 clk = ~clk;

    fp8e4_unpack_stream #(.LANES(LANES)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .in_valid_i(in_valid),
        .in_ready_o(in_ready),
        .in_data_i(in_data),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_f32_o(out_f32),
        .out_lane_o(out_lane),
        .out_last_o(out_last),
        .out_spc_o(out_spc)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, got, want);
        end
    endtask

    // value = (8+m)*2^(e-10) for normals, m*2^-9 for subnormals, then renormalised
    function automatic logic [31:0] ref_f32(input logic [7:0] b);
        int e, m, k;
        real v;
        e = int'(b[6:3]);
        m = int'(b[2:0]);
        if (e == 15) return {b[7], 8'hFF, m != 0 ? 23'h400000 : 23'h0};
        if (e == 0 && m == 0) return {b[7], 31'b0};
        v = (e == 0) ? real'(m) : real'(8 + m);
        k = (e == 0) ? -9 : e - 10;
        while (v >= 2.0) begin v = v / 2.0; k++; end
        while (v < 1.0) begin v = v * 2.0; k--; end
        return {b[7], 8'(k + 127), 23'($rtoi((v - 1.0) * 8388608.0))};
    endfunction

    function automatic logic [7:0] pack(input logic [31:0] f);
        logic [7:0] x;
        logic [3:0] mm;
        x = f[30:23];
        if (x == 8'd255) return {f[31], 4'hF, f[22:0] != 0 ? 3'b001 : 3'b000};
        if (x == 8'd0) return {f[31], 7'b0};
        if (x >= 8'd121) return {f[31], 4'(x - 8'd120), f[22:20]};
        mm = {1'b1, f[22:20]} >> (8'd121 - x);
        return {f[31], 4'b0, mm[2:0]};
    endfunction

    function automatic logic [7:0] rt(input logic [7:0] b);
        return (b[6:3] == 4'hF && b[2:0] != 0) ? {b[7], 4'hF, 3'b001} : b;
    endfunction

    always @(posedge clk) if (rst) q.delete();

    always @(negedge clk) if (!rst) begin
        if (out_valid && out_ready) begin
            if (q.size() == 0) chk("unexpected_out", 32'(out_valid), 0);
            else begin
                e_sb = q.pop_front();
                chk("sb_f32", out_f32, ref_f32(e_sb.b));
                chk("sb_lane", 32'(out_lane), 32'(e_sb.lane));
                chk("sb_last", 32'(out_last), 32'(e_sb.lane == LANES - 1));
                chk("sb_spc", 32'(out_spc), 32'(e_sb.b[6:3] == 4'hF));
                chk("sb_roundtrip", 32'(pack(out_f32)), 32'(rt(e_sb.b)));
            end
        end
        if (in_valid && in_ready)
            for (int k = 0; k < LANES; k++) q.push_back('{in_data[8*k +: 8], k});
    end

    task automatic send_word(input logic [31:0] w);
        int t;
        t = 0;
        @(posedge clk); #1;
        in_data = w;
        in_valid = 1;
        @(negedge clk);
        while (!in_ready && t < 50) begin @(negedge clk); t++; end
        chk("send_ready", 32'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic idle();
        int t;
        t = 0;
        @(negedge clk);
        while (out_valid && t < 50) begin @(negedge clk); t++; end
        chk("idle", 32'(out_valid), 0);
    endtask

    task automatic run_word(input logic [31:0] w, input logic [3:0][31:0] ex);
        send_word(w);
        @(negedge clk);
        chk("lat_pre", 32'(out_valid), 0);
        for (int k = 0; k < LANES; k++) begin
            @(negedge clk);
            chk("valid", 32'(out_valid), 1);
            chk("f32", out_f32, ex[k]);
            chk("lane", 32'(out_lane), 32'(k));
            chk("last", 32'(out_last), 32'(k == LANES - 1));
            chk("spc", 32'(out_spc), 32'(w[8*k+3 +: 4] == 4'hF));
        end
        @(negedge clk);
        chk("drain", 32'(out_valid), 0);
    endtask

    function automatic logic [3:0][31:0] ref_word(input logic [31:0] w);
        logic [3:0][31:0] r;
        for (int k = 0; k < 4; k++) r[k] = ref_f32(w[8*k +: 8]);
        return r;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic [31:0] w;
        logic [31:0] words[8];
        logic [3:0][31:0] ex;
        logic acc;
        int n, t;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_f32", out_f32, 0);
        chk("rst_lane", 32'(out_lane), 0);
        chk("rst_last", 32'(out_last), 0);
        chk("rst_spc", 32'(out_spc), 0);
        chk("rst_ready", 32'(in_ready), 0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("post_rst_ready", 32'(in_ready), 1);

        run_word(32'h80004038, {32'h80000000, 32'h00000000, 32'h40000000, 32'h3F800000});
        run_word(32'h0177F978, {32'h3B000000, 32'h43700000, 32'hFFC00000, 32'h7F800000});
        run_word(32'h00830207, {32'h00000000, 32'hBBC00000, 32'h3B800000, 32'h3C600000});

        w = $urandom;
        ex = ref_word(w);
        send_word(w);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        out_ready = 0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            chk("bp_f32", out_f32, ex[1]);
            chk("bp_lane", 32'(out_lane), 1);
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_in_ready", 32'(in_ready), 0);
        end
        @(posedge clk); #1;
        out_ready = 1;
        @(negedge clk);
        chk("bp_hold_lane", 32'(out_lane), 1);
        @(negedge clk);
        chk("bp_resume_lane", 32'(out_lane), 2);
        chk("bp_resume_f32", out_f32, ex[2]);
        idle();

        for (int i = 0; i < 8; i++) words[i] = $urandom;
        @(posedge clk); #1;
        in_data = words[0];
        in_valid = 1;
        n = 0;
        for (int i = 0; i <= 34; i++) begin
            @(negedge clk);
            chk("b2b_in_ready", 32'(in_ready), 32'(i % 4 == 0 || i >= 32));
            chk("b2b_out_valid", 32'(out_valid), 32'(i >= 2 && i <= 33));
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) begin
                n++;
                if (n == 8) in_valid = 0;
                else in_data = words[n];
            end
        end
        chk("b2b_words", 32'(n), 8);

        w = $urandom;
        send_word(w);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        chk("mid_lane1", 32'(out_lane), 1);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_ready", 32'(in_ready), 1);
        w = $urandom;
        run_word(w, ref_word(w));

        for (int j = 0; j < 64; j++)
            send_word({8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)});
        idle();

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc || !in_valid) begin
                in_valid = $urandom_range(0, 3) != 0;
                in_data = $urandom;
            end
            out_ready = $urandom_range(0, 3) != 0;
        end
        @(negedge clk);
        acc = in_valid && in_ready;
        @(posedge clk); #1;
        in_valid = 0;
        out_ready = 1;
        t = 0;
        @(negedge clk);
        while ((q.size() != 0 || out_valid) && t < 100) begin @(negedge clk); t++; end
        chk("final_queue", 32'(q.size()), 0);
        chk("final_idle", 32'(out_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
